clk_en_sched: RTL and testbench
===============================

Name: clk_en_sched

Overview:
- Round-robin clock-enable scheduler that shares one clock-enable slot among NREQ requesters.
- Each grant lasts a per-requester burst length, measured in enabled cycles.
- Counts enabled cycles against a programmable run budget, then signals done, so benches can end a run on a cycle count.
- Sits between the free-running clk and the per-requester logic that advances only when granted.

Parameters:
NREQ, 4, number of requesters (2..16)
CNT_W, 16, width of cycle budget and cycle counter
BURST_W, 4, width of each per-requester burst length

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  pulse: latch cycle_limit, begin run
stop  input  1  pulse: abort run, return to IDLE
cycle_limit  input  CNT_W  run budget in enabled cycles, latched on accepted start
req  input  NREQ  level request per requester
burst_len  input  NREQ*BURST_W  burst length for requester i in bits [i*BURST_W +: BURST_W], sampled at arbitration
grant  output  NREQ  one-hot grant, registered
clk_en  output  1  OR of grant, registered
owner  output  $clog2(NREQ)  index of current or last grantee
cyc  output  CNT_W  enabled cycles counted this run
busy  output  1  high in ARB or GRANT
done  output  1  high in DONE

Behaviour:
- Reset, taken when rst_n is low at posedge: state=IDLE; grant=0, clk_en=0, owner=0, cyc=0, busy=0, done=0; round-robin pointer last=NREQ-1, so requester 0 has first priority.
- All outputs are registered. No combinational path exists from any input to any output.
- States are IDLE, ARB, GRANT and DONE.
- IDLE:
  - start=1 and stop=0: latch limit=cycle_limit, cyc<=0.
  - Next state is ARB, or DONE if limit==0.
  - start and stop both high: stop wins, stay IDLE.
- ARB, a one-cycle bubble with clk_en=0:
  - Search req from index last+1 upward, wrapping modulo NREQ.
  - On the first hit k: owner<=k, last<=k, rem<=burst_len[k], with 0 treated as 1; grant<=onehot(k); next state GRANT.
  - No req: stay in ARB with grant=0.
  - cyc does not advance in ARB.
- GRANT:
  - grant[owner]=1 and clk_en=1 every cycle; each GRANT cycle does cyc<=cyc+1 and rem<=rem-1.
  - Exit priority, evaluated each cycle:
    1. stop → IDLE, grant cleared next cycle; cyc holds its value, done=0.
    2. cyc+1==limit → DONE; grant cleared next cycle; the cycle still counts, so cyc ends equal to limit.
    3. rem==1 or req[owner]==0 → ARB, grant cleared next cycle; the cycle still counts.
    4. Otherwise stay in GRANT.
  - Only one requester is ever granted. Grant never switches owners without an intervening ARB cycle.
- DONE:
  - done=1, busy=0; cyc holds limit.
  - start re-latches the limit, clears cyc and done, and goes to ARB (or stays DONE if the new limit is 0).
  - stop → IDLE with done cleared.
- start while busy is ignored. stop in IDLE is a no-op.
- cyc never wraps: the limit is reached first. limit=2^CNT_W-1 is legal.
- The round-robin pointer is not reset by start or stop; only rst_n resets it.
- Reset mid-run takes effect at the next posedge: all outputs return to reset values that cycle.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start=1 and req=all ones → grant=0, clk_en=0, cyc=0, busy=0, done=0 throughout.
- Single requester: req=0001, burst_len[0]=3, cycle_limit=10, pulse start.
  - clk_en after start is 0,1,1,1,0,1,1,1,0,1,1,1,0,1.
  - done=1 on the following cycle with cyc=10; grant only ever 0001.
- Round-robin: req=1111, all bursts 2, limit=16.
  - Owners in order 0,1,2,3,0,1,2,3, each holding 2 enabled cycles with one ARB bubble between grants; done with cyc=16.
- Limit mid-burst and zero limit:
  - req=0010, burst 15, limit=5 → exactly 5 clk_en cycles, then done, cyc=5.
  - A new start with limit=0 → DONE directly, clk_en never high.
- Stop and request drop:
  - req=0001, burst 8: assert stop at the 3rd enabled cycle → IDLE, cyc=3, done=0, grant=0 next cycle.
  - Separately, drop req[0] at the 2nd enabled cycle → that cycle is counted and grant=0 the next cycle.
- Start/stop collision and reset mid-run:
  - start and stop together in IDLE → stays IDLE, busy=0.
  - rst_n low during GRANT → all outputs at reset values on the next cycle; a fresh start then grants requester 0 first.

Source files
------------

// File: rtl/clk_en_sched.sv
// Round-robin clock-enable scheduler.
// Shares a single clock-enable slot among NREQ requesters. Each grant lasts up to a
// per-requester burst length, counted in enabled cycles. A programmable run budget
// bounds the total number of enabled cycles. When the budget is used up, done is raised.
//
// Ports:
//   clk          free-running clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   start        pulse: latch cycle_limit and begin a run (ignored while busy)
//   stop         pulse: abort the run and return to idle (wins over start)
//   cycle_limit  run budget in enabled cycles
//   req          level request per requester
//   burst_len    burst length of requester i in [i*BURST_W +: BURST_W]; 0 acts as 1
//   grant        registered one-hot grant
//   clk_en       registered OR of grant
//   owner        index of the current or most recent grantee
//   cyc          enabled cycles counted in this run
//   busy         high while arbitrating or granting
//   done         high once the budget is exhausted
module clk_en_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 4,
  localparam int unsigned OW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        cycle_limit,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BURST_W-1:0] burst_len,
  output logic [NREQ-1:0]         grant,
  output logic                    clk_en,
  output logic [OW-1:0]           owner,
  output logic [CNT_W-1:0]        cyc,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StArb, StGrant, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   limit_q;
  logic [BURST_W-1:0] rem_q;
  logic [OW-1:0]      last_q;

  logic               arb_hit;
  logic [OW-1:0]      arb_pick;
  logic [BURST_W-1:0] arb_burst;
  int unsigned        idx;
  logic [CNT_W-1:0]   cyc_nxt;

  // Round-robin search starting just after the last grantee, wrapping modulo NREQ.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = '0;
    idx      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_q) + i) % NREQ;
      if (!arb_hit && req[idx[OW-1:0]]) begin
        arb_hit  = 1'b1;
        arb_pick = idx[OW-1:0];
      end
    end
    arb_burst = BURST_W'(burst_len >> (32'(arb_pick) * BURST_W));
    if (arb_burst == '0) begin
      arb_burst = BURST_W'(1);
    end
  end

  // cyc < limit holds throughout GRANT, so this increment cannot wrap.
  assign cyc_nxt = cyc + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant   <= '0;
      clk_en  <= 1'b0;
      owner   <= '0;
      cyc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      limit_q <= '0;
      rem_q   <= '0;
      last_q  <= OW'(NREQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            limit_q <= cycle_limit;
            cyc     <= '0;
            if (cycle_limit == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StArb;
              busy    <= 1'b1;
            end
          end
        end
        StArb: begin
          if (stop) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (arb_hit) begin
            owner   <= arb_pick;
            last_q  <= arb_pick;
            rem_q   <= arb_burst;
            grant   <= NREQ'(1) << arb_pick;
            clk_en  <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          // Every granted cycle counts, including the one that ends the grant.
          cyc   <= cyc_nxt;
          rem_q <= rem_q - BURST_W'(1);
          if (stop) begin
            state_q <= StIdle;
            grant   <= '0;
            clk_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (cyc_nxt == limit_q) begin
            state_q <= StDone;
            grant   <= '0;
            clk_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (rem_q == BURST_W'(1) || !req[owner]) begin
            state_q <= StArb;
            grant   <= '0;
            clk_en  <= 1'b0;
          end
        end
        StDone: begin
          if (stop) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end else if (start) begin
            limit_q <= cycle_limit;
            cyc     <= '0;
            if (cycle_limit != '0) begin
              state_q <= StArb;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_sched.sv
module tb_clk_en_sched;
  localparam int NREQ  = 4;
  localparam int CNT_W = 16;
  localparam int BW    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n, start, stop;
  logic [CNT_W-1:0]     cycle_limit;
  logic [NREQ-1:0]      req;
  logic [NREQ*BW-1:0]   burst_len;
  logic [NREQ-1:0]      grant;
  logic                 clk_en;
  logic [1:0]           owner;
  logic [CNT_W-1:0]     cyc;
  logic                 busy, done;

  always #5 clk = ~clk;

  clk_en_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cycle_limit(cycle_limit),
    .req(req), .burst_len(burst_len), .grant(grant), .clk_en(clk_en), .owner(owner),
    .cyc(cyc), .busy(busy), .done(done)
  );

  // Expected events: a finished grant segment (owner, length) or a done with final count.
  typedef struct {bit is_done; int owner; int len;} exp_t;
  exp_t expq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = NREQ - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: split the budget into grants, walking requesters round-robin.
  task automatic model_run(input logic [NREQ-1:0] r, input logic [NREQ*BW-1:0] b,
                           input int limit);
    int remaining;
    int p;
    remaining = limit;
    p = model_last;
    while (remaining > 0) begin
      int k;
      int blen;
      int len;
      k = -1;
      for (int i = 1; i <= NREQ; i++) begin
        if (k < 0 && r[(p + i) % NREQ]) k = (p + i) % NREQ;
      end
      blen = int'((b >> (k * BW)) & ((1 << BW) - 1));
      if (blen == 0) blen = 1;
      len = (blen < remaining) ? blen : remaining;
      expq.push_back('{is_done: 1'b0, owner: k, len: len});
      remaining -= len;
      p = k;
    end
    model_last = p;
    expq.push_back('{is_done: 1'b1, owner: 0, len: limit});
  endtask

  // Monitor: reconstruct grant segments and done events, compare against the queue.
  bit prev_en   = 1'b0;
  bit prev_done = 1'b0;
  int seg_len   = 0;
  int seg_owner = 0;

  task automatic pop_cmp(input bit is_done_ev);
    exp_t e;
    if (expq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got done=%0d event, expected none", is_done_ev);
    end else begin
      e = expq.pop_front();
      chk("event_kind", is_done_ev, e.is_done);
      if (is_done_ev) begin
        chk("done_cyc", cyc, e.len);
      end else begin
        chk("seg_owner", seg_owner, e.owner);
        chk("seg_len", seg_len, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (clk_en) begin
      chk("grant_onehot", grant, 64'(1) << owner);
      chk("busy_in_grant", busy, 1);
      if (!prev_en) begin
        seg_len   = 1;
        seg_owner = owner;
      end else begin
        seg_len++;
        chk("owner_stable", owner, seg_owner);
      end
    end else begin
      chk("grant_idle", grant, 0);
      if (prev_en) pop_cmp(1'b0);
    end
    if (done && !prev_done) pop_cmp(1'b1);
    prev_en   = clk_en;
    prev_done = done;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int limit);
    cycle_limit = CNT_W'(limit);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic wait_en(input int budget);
    int k;
    k = 0;
    while (!clk_en && k < budget) begin
      step();
      k++;
    end
    chk("en_reached", clk_en, 1);
  endtask

  task automatic run(input logic [NREQ-1:0] r, input logic [NREQ*BW-1:0] b, input int limit);
    req = r;
    burst_len = b;
    model_run(r, b, limit);
    pulse_start(limit);
    wait_done(3 * limit + 20);
    chk("final_cyc", cyc, limit);
    chk("busy_at_done", busy, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    stop = 1'b0;
    req = '1;
    burst_len = '0;
    cycle_limit = 16'd5;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_clk_en", clk_en, 0);
      chk("rst_cyc", cyc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();

    // Round-robin, all bursts 2: owners 0,1,2,3,0,1,2,3.
    run(4'b1111, 16'h2222, 16);
    // Single requester, burst 3, limit 10.
    run(4'b0001, 16'h0003, 10);
    // Limit lands mid-burst.
    run(4'b0010, 16'h00F0, 5);

    // Zero limit from DONE: stays done, count cleared, no enable.
    cycle_limit = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_cyc", cyc, 0);
    chk("zero_busy", busy, 0);
    repeat (4) begin
      step();
      chk("zero_no_en", clk_en, 0);
    end

    // Stop during the 3rd enabled cycle.
    req = 4'b0001;
    burst_len = 16'h0008;
    expq.push_back('{is_done: 1'b0, owner: 0, len: 3});
    model_last = 0;
    pulse_start(100);
    wait_en(10);
    step(2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_cyc", cyc, 3);
    chk("stop_done", done, 0);
    chk("stop_grant", grant, 0);
    chk("stop_busy", busy, 0);

    // Drop request during the 2nd enabled cycle.
    expq.push_back('{is_done: 1'b0, owner: 0, len: 2});
    pulse_start(100);
    wait_en(10);
    step();
    req = 4'b0000;
    step();
    chk("drop_grant", grant, 0);
    chk("drop_cyc", cyc, 2);
    chk("drop_busy_arb", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("drop_stop_busy", busy, 0);

    // start and stop together in IDLE: stop wins.
    req = 4'b0001;
    cycle_limit = 16'd20;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("coll_busy", busy, 0);
    chk("coll_done", done, 0);
    step();
    chk("coll_busy2", busy, 0);
    chk("coll_clk_en", clk_en, 0);

    // Reset during GRANT, then a fresh start grants requester 0 first.
    req = 4'b0100;
    burst_len = 16'h0F00;
    expq.push_back('{is_done: 1'b0, owner: 2, len: 2});
    pulse_start(100);
    wait_en(10);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_clk_en", clk_en, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    req = 4'b1111;
    burst_len = 16'h1111;
    model_run(req, burst_len, 6);
    pulse_start(6);
    wait_en(10);
    chk("fresh_owner", owner, 0);
    wait_done(40);
    step();

    // Randomized runs against the reference model.
    for (int it = 0; it < 25; it++) begin
      logic [NREQ-1:0]    r;
      logic [NREQ*BW-1:0] b;
      int                 lim;
      r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      b   = (NREQ*BW)'($urandom);
      lim = int'($urandom_range(1, 60));
      run(r, b, lim);
    end

    step(3);
    chk("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
